// File: rtl/rcv_bit_ctrl.sv
// rtl/rcv_bit_ctrl.sv - receive-side bit timing, stop-bit check and output buffering
// Strobes an external serial-to-parallel register at mid-bit and latches completed bytes.
module rcv_bit_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int NUM_BITS     = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                serial_in,
  input  logic [NUM_BITS:0]   sr_data,
  input  logic                data_read,
  output logic                shift_enable,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                data_ready,
  output logic                overrun_error,
  output logic                framing_error
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(NUM_BITS + 2);
  localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_BITS);

  typedef enum logic [2:0] {IDLE, START_CHK, RECV, STOP_CHK, LOAD} state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                prev_line_q;
  logic [NUM_BITS-1:0] rx_data_q, rx_data_d;
  logic                data_ready_q, data_ready_d;
  logic                overrun_q, overrun_d;
  logic                framing_q, framing_d;
  logic                mid_bit;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      prev_line_q  <= 1'b1;
      rx_data_q    <= '1;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      prev_line_q  <= serial_in;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      framing_q    <= framing_d;
    end
  end

  // Timer runs modulo one bit period from the edge, so every strobe lands on the same count.
  assign mid_bit = (timer_q == T_MID);

  always_comb begin
    state_d      = state_q;
    timer_d      = (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
    bit_cnt_d    = bit_cnt_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    framing_d    = framing_q;
    shift_enable = 1'b0;

    if (data_read) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (prev_line_q && !serial_in) begin
          state_d   = START_CHK;
          framing_d = 1'b0;
        end
      end
      START_CHK: begin
        if (mid_bit) begin
          if (serial_in) begin
            state_d = IDLE;
          end else begin
            state_d   = RECV;
            bit_cnt_d = '0;
          end
        end
      end
      RECV: begin
        if (mid_bit) begin
          shift_enable = 1'b1;
          bit_cnt_d    = bit_cnt_q + CW'(1);
          if (bit_cnt_q == C_LAST) state_d = STOP_CHK;
        end
      end
      STOP_CHK: begin
        if (sr_data[NUM_BITS]) begin
          state_d = LOAD;
        end else begin
          framing_d = 1'b1;
          state_d   = IDLE;
        end
      end
      LOAD: begin
        // A read in the same cycle retires the old byte, so the load is not an overrun.
        rx_data_d    = sr_data[NUM_BITS-1:0];
        data_ready_d = 1'b1;
        overrun_d    = data_ready_q & ~data_read;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) timer_d = '0;
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;

endmodule

// File: tb/tb_rcv_bit_ctrl.sv
// tb/tb_rcv_bit_ctrl.sv - directed self-checking bench for rcv_bit_ctrl with a 9-bit shift register model
module tb_rcv_bit_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       serial_in;
  logic [8:0] sr_q;
  logic       data_read;
  logic       shift_enable;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sr_q <= '1;
    else if (shift_enable) sr_q <= {serial_in, sr_q[8:1]};
  end

  rcv_bit_ctrl #(.CLKS_PER_BIT(10), .NUM_BITS(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .sr_data      (sr_q),
    .data_read    (data_read),
    .shift_enable (shift_enable),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error)
  );

  typedef struct {
    logic [7:0] d;
    logic       stop;
    bit         rd_mid;
    bit         rd_load;
    int         gap;
    logic [7:0] exp_rx;
    logic       exp_rdy;
    logic       exp_ovr;
    logic       exp_frm;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    logic [9:0] bits;
    int pcnt, pbad;
    logic [7:0] s_rx;
    logic s_rdy, s_ovr, s_frm, frm_e;
    bits = {vecs[i].stop, vecs[i].d, 1'b0};
    pcnt = 0; pbad = 0;
    s_rx = '0; s_rdy = 1'b0; s_ovr = 1'b0; s_frm = 1'b0; frm_e = 1'b1;
    for (int n = 0; n < 100; n++) begin
      serial_in = bits[n / 10];
      data_read = (vecs[i].rd_mid && n == 50) || (vecs[i].rd_load && n == 97);
      @(negedge clk);
      if (shift_enable) begin
        pcnt++;
        if (n < 15 || (n % 10) != 5) pbad++;
      end
      if (n == 2) frm_e = framing_error;
      if (n == 98) begin
        s_rx = rx_data; s_rdy = data_ready; s_ovr = overrun_error; s_frm = framing_error;
      end
      tick();
    end
    serial_in = 1'b1;
    data_read = 1'b0;
    check($sformatf("v%0d shift_pulses", i), pcnt, 9);
    check($sformatf("v%0d shift_misplaced", i), pbad, 0);
    check($sformatf("v%0d framing_at_edge", i), frm_e, 0);
    check($sformatf("v%0d rx_data", i), s_rx, vecs[i].exp_rx);
    check($sformatf("v%0d data_ready", i), s_rdy, vecs[i].exp_rdy);
    check($sformatf("v%0d overrun", i), s_ovr, vecs[i].exp_ovr);
    check($sformatf("v%0d framing", i), s_frm, vecs[i].exp_frm);
    repeat (vecs[i].gap) tick();
  endtask

  initial begin
    int se_cnt, rdy_cnt;
    logic [9:0] bits;

    vecs[0] = '{8'hA5, 1'b1, 0, 0, 0,  8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1, 0, 10, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 0, 0, 0,  8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h55, 1'b1, 1, 0, 0,  8'h55, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hAA, 1'b1, 0, 0, 5,  8'hAA, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h0F, 1'b1, 0, 0, 0,  8'h0F, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hF0, 1'b1, 0, 1, 5,  8'hF0, 1'b1, 1'b0, 1'b0};

    n_rst = 1'b0; serial_in = 1'b1; data_read = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset shift_enable", shift_enable, 0);
    check("reset rx_data", rx_data, 8'hFF);
    check("reset data_ready", data_ready, 0);
    check("reset overrun", overrun_error, 0);
    check("reset framing", framing_error, 0);
    tick();
    n_rst = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 5; i++) run_vec(i);

    // false start: low for 3 cycles only
    se_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      serial_in = (n < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (shift_enable) se_cnt++;
      tick();
    end
    check("false_start shift_pulses", se_cnt, 0);
    check("false_start rx_data", rx_data, 8'hAA);
    check("false_start data_ready", data_ready, 1);
    check("false_start overrun", overrun_error, 1);
    check("false_start framing", framing_error, 0);

    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    @(negedge clk);
    check("read data_ready", data_ready, 0);
    check("read overrun", overrun_error, 0);
    check("read rx_data", rx_data, 8'hAA);
    tick();

    for (int i = 5; i < 7; i++) run_vec(i);

    // reset asserted at E+35 of a frame
    bits = {1'b1, 8'h99, 1'b0};
    for (int n = 0; n <= 35; n++) begin
      serial_in = bits[n / 10];
      if (n == 35) n_rst = 1'b0;
      @(negedge clk);
      if (n < 35) tick();
    end
    check("midreset shift_enable", shift_enable, 0);
    check("midreset rx_data", rx_data, 8'hFF);
    check("midreset data_ready", data_ready, 0);
    check("midreset overrun", overrun_error, 0);
    check("midreset framing", framing_error, 0);
    tick();
    serial_in = 1'b1;
    tick();
    n_rst = 1'b1;
    se_cnt = 0; rdy_cnt = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (shift_enable) se_cnt++;
      if (data_ready) rdy_cnt++;
      tick();
    end
    check("post_reset shift_pulses", se_cnt, 0);
    check("post_reset data_ready", rdy_cnt, 0);
    check("post_reset rx_data", rx_data, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
